// File: rtl/dsam_pkg.sv
// DSAM shared defaults, word layout and decoder state encoding.
package dsam_pkg;

  localparam int DSAM_DATA_WIDTH = 16;
  localparam int DSAM_CHANNELS   = 256;
  localparam int SIGN_BIT        = DSAM_DATA_WIDTH - 1;

  typedef struct packed {
    logic                       sign;
    logic [DSAM_DATA_WIDTH-2:0] corr;
  } dsam_word_t;

  typedef enum logic {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } dsam_state_e;

endpackage

// File: rtl/dsam_history_ram.sv
// Per-channel sample history: simple dual-port RAM,
// synchronous read, single write port, no reset.
module dsam_history_ram
  import dsam_pkg::*;
#(
  parameter int  DATA_WIDTH = DSAM_DATA_WIDTH,
  parameter int  CHANNELS   = DSAM_CHANNELS,
  localparam int AW         = $clog2(CHANNELS)
) (
  input  logic                  clk,
  input  logic                  rd_en_i,
  input  logic [AW-1:0]         rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  input  logic                  wr_en_i,
  input  logic [AW-1:0]         wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i
);

  logic [DATA_WIDTH-1:0] mem_q [CHANNELS];
  logic [DATA_WIDTH-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_q;

endmodule

// File: rtl/dsam_decoder.sv
// DSAM stream decoder: undoes running-XOR correlation,
// then the per-channel differential stage.
module dsam_decoder
  import dsam_pkg::*;
#(
  parameter int  DATA_WIDTH = DSAM_DATA_WIDTH,
  parameter int  CHANNELS   = DSAM_CHANNELS,
  localparam int CH_WIDTH   = $clog2(CHANNELS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out,
  output logic [CH_WIDTH-1:0]   out_ch
);

  localparam int CW = DATA_WIDTH - 1;
  localparam logic [CH_WIDTH-1:0] LAST_CH =
    CH_WIDTH'(CHANNELS - 1);

  dsam_state_e           state_q, state_d;
  logic [CH_WIDTH-1:0]   ch_q, ch_d;
  logic [CW-1:0]         prev_corr_q;
  logic [DATA_WIDTH-1:0] sub;

  logic                  s1_valid_q;
  logic [DATA_WIDTH-1:0] s1_sub_q;
  logic [CH_WIDTH-1:0]   s1_ch_q;
  logic                  s1_warm_q;

  logic [DATA_WIDTH-1:0] hist_rd;
  logic [DATA_WIDTH-1:0] sample;

  logic                  s2_valid_q;
  logic [DATA_WIDTH-1:0] s2_sample_q;
  logic [CH_WIDTH-1:0]   s2_ch_q;

  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_q;
  logic [CH_WIDTH-1:0]   out_ch_q;

  assign sub = {in[CW], in[CW-1:0] ^ prev_corr_q};

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    if (in_valid) begin
      ch_d = (ch_q == LAST_CH) ? '0
                               : ch_q + CH_WIDTH'(1);
      unique case (state_q)
        WARMUP: if (ch_q == LAST_CH) state_d = RUN;
        RUN:    state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= WARMUP;
      ch_q        <= '0;
      prev_corr_q <= '0;
      s1_valid_q  <= 1'b0;
      s1_sub_q    <= '0;
      s1_ch_q     <= '0;
      s1_warm_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      s1_valid_q <= in_valid;
      if (in_valid) begin
        prev_corr_q <= in[CW-1:0];
        s1_sub_q    <= sub;
        s1_ch_q     <= ch_q;
        s1_warm_q   <= (state_q == RUN);
      end
    end
  end

  // Warm flag travels with the word so the boundary word stays raw.
  assign sample = s1_warm_q ? hist_rd + s1_sub_q
                            : s1_sub_q;

  dsam_history_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .CHANNELS   (CHANNELS)
  ) u_hist (
    .clk       (clk),
    .rd_en_i   (in_valid),
    .rd_addr_i (ch_q),
    .rd_data_o (hist_rd),
    .wr_en_i   (s1_valid_q),
    .wr_addr_i (s1_ch_q),
    .wr_data_i (sample)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid_q  <= 1'b0;
      s2_sample_q <= '0;
      s2_ch_q     <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      out_ch_q    <= '0;
    end else begin
      s2_valid_q  <= s1_valid_q;
      out_valid_q <= s2_valid_q;
      if (s1_valid_q) begin
        s2_sample_q <= sample;
        s2_ch_q     <= s1_ch_q;
      end
      if (s2_valid_q) begin
        out_q    <= s2_sample_q;
        out_ch_q <= s2_ch_q;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_dsam_decoder.sv
// Directed self-checking bench for dsam_decoder
// (DATA_WIDTH=16, CHANNELS=4).
module tb_dsam_decoder;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [15:0] in;
  logic        out_valid;
  logic [15:0] out;
  logic [1:0]  out_ch;

  int checks   = 0;
  int failures = 0;

  dsam_decoder #(
    .DATA_WIDTH (16),
    .CHANNELS   (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in        (in),
    .out_valid (out_valid),
    .out       (out),
    .out_ch    (out_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, got, exp);
    end
  endtask

  // Check outputs at the falling edge, then drive next input.
  task automatic cyc(input string tag,
                     input logic v,
                     input logic [15:0] w,
                     input logic ev,
                     input logic [15:0] eo,
                     input logic [1:0] ech);
    @(negedge clk);
    chk({tag, ".valid"}, 32'(out_valid), 32'(ev));
    if (ev) begin
      chk({tag, ".out"}, 32'(out), 32'(eo));
      chk({tag, ".ch"}, 32'(out_ch), 32'(ech));
    end
    in_valid = v;
    in       = w;
  endtask

  // Asynchronous reset asserted mid-cycle, released at a falling edge.
  task automatic do_reset(input string tag);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk({tag, ".rst_out"}, 32'(out), 32'h0);
    chk({tag, ".rst_ch"}, 32'(out_ch), 32'h0);
    chk({tag, ".rst_valid"}, 32'(out_valid), 32'h0);
    in_valid = 1'b0;
    in       = 16'h0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in       = 16'h0;

    do_reset("init");

    // Warm-up XOR undo
    cyc("wu0", 1, 16'h0003, 0, 16'h0, 2'd0);
    cyc("wu1", 1, 16'h0005, 0, 16'h0, 2'd0);
    cyc("wu2", 1, 16'h0006, 0, 16'h0, 2'd0);
    cyc("wu3", 1, 16'h8006, 1, 16'h0003, 2'd0);
    cyc("wu4", 0, 16'h0000, 1, 16'h0006, 2'd1);
    cyc("wu5", 0, 16'h0000, 1, 16'h0003, 2'd2);
    cyc("wu6", 0, 16'h0000, 1, 16'h8000, 2'd3);
    cyc("wu7", 0, 16'h0000, 0, 16'h0, 2'd0);
    chk("wu7.hold_out", 32'(out), 32'h8000);
    chk("wu7.hold_ch", 32'(out_ch), 32'h3);

    // Differential and modular wrap
    do_reset("dif");
    cyc("df0", 1, 16'h0010, 0, 16'h0, 2'd0);
    cyc("df1", 1, 16'hFFEF, 0, 16'h0, 2'd0);
    cyc("df2", 1, 16'h7FEF, 0, 16'h0, 2'd0);
    cyc("df3", 1, 16'h7FEF, 1, 16'h0010, 2'd0);
    cyc("df4", 1, 16'h7FEA, 1, 16'hFFFF, 2'd1);
    cyc("df5", 1, 16'h7FE8, 1, 16'h0000, 2'd2);
    cyc("df6", 0, 16'h0000, 1, 16'h0000, 2'd3);
    cyc("df7", 0, 16'h0000, 1, 16'h0015, 2'd0);
    cyc("wrap", 0, 16'h0000, 1, 16'h0001, 2'd1);
    cyc("df9", 0, 16'h0000, 0, 16'h0, 2'd0);

    // Stall: gap words must not disturb prev_corr or ch
    do_reset("stl");
    cyc("st0", 1, 16'h0003, 0, 16'h0, 2'd0);
    cyc("st1", 0, 16'h7FFF, 0, 16'h0, 2'd0);
    cyc("st2", 0, 16'h7FFF, 0, 16'h0, 2'd0);
    cyc("st3", 1, 16'h0005, 1, 16'h0003, 2'd0);
    cyc("st4", 1, 16'h0006, 0, 16'h0, 2'd0);
    chk("st4.hold_out", 32'(out), 32'h0003);
    chk("st4.hold_ch", 32'(out_ch), 32'h0);
    cyc("st5", 1, 16'h8006, 0, 16'h0, 2'd0);
    cyc("st6", 1, 16'h0000, 1, 16'h0006, 2'd1);
    cyc("st7", 1, 16'h0001, 1, 16'h0003, 2'd2);

    // Reset with words in flight, then fresh warm-up
    do_reset("mid");
    cyc("rm0", 1, 16'h0001, 0, 16'h0, 2'd0);
    cyc("rm1", 1, 16'h0003, 0, 16'h0, 2'd0);
    cyc("rm2", 1, 16'h0003, 0, 16'h0, 2'd0);
    cyc("rm3", 1, 16'h0007, 1, 16'h0001, 2'd0);
    cyc("rm4", 1, 16'h0004, 1, 16'h0002, 2'd1);
    cyc("rm5", 0, 16'h0000, 1, 16'h0000, 2'd2);
    cyc("rm6", 0, 16'h0000, 1, 16'h0004, 2'd3);
    cyc("rm7", 0, 16'h0000, 1, 16'h0004, 2'd0);
    cyc("rm8", 0, 16'h0000, 0, 16'h0, 2'd0);
    chk("rm8.hold_out", 32'(out), 32'h0004);
    chk("rm8.hold_ch", 32'(out_ch), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
